// File: rtl/stack_arb_pkg.sv
// -----------------------------------------------------------------------------
// stack_arb_pkg
// Shared definitions for the stack arbiter slice:
//   - state_t     : arbiter FSM encoding (IDLE / ISSUE / RESP)
//   - OP_PUSH/POP : encoding of the per-requester op bit and stk_push_pop
//   - DEFAULT_DATA_W, STACK_DEPTH : geometry of the shared LIFO
// -----------------------------------------------------------------------------
package stack_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam logic OP_PUSH = 1'b1;
   localparam logic OP_POP  = 1'b0;

   localparam int DEFAULT_DATA_W = 8;
   localparam int STACK_DEPTH    = 8;

endpackage

// File: rtl/stack_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Searches i_req starting one above
// i_last and wrapping around; the first set bit wins.
// Ports:
//   i_req  [N-1:0]  request vector
//   i_last [IW-1:0] index of the previous winner (search starts at i_last+1)
//   o_gnt  [N-1:0]  one-hot grant (all zero when no request)
//   o_idx  [IW-1:0] binary index of the winner (0 when no request)
// -----------------------------------------------------------------------------
module rr_arbiter
   import stack_arb_pkg::*;
#(
   parameter  int N  = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_last,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx
);

   logic [IW-1:0] w_cand;
   logic          w_found;

   // NOTE: every combinational output gets a default before any branch, so no
   // path through the block leaves a value held and no latch is inferred.
   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_cand  = '0;
      // Offsets 1..N visit every requester once, the previous winner last.
      for (int k = 1; k <= N; k++) begin
         w_cand = IW'((int'(i_last) + k) % N);
         if (!w_found && i_req[w_cand]) begin
            w_found       = 1'b1;
            o_gnt[w_cand] = 1'b1;
            o_idx         = w_cand;
         end
      end
   end

endmodule

// File: rtl/stack_arbiter.sv
// -----------------------------------------------------------------------------
// stack_arbiter
// Shares one LIFO stack between NUM_REQ requesters. Each request is a
// req/ack handshake; one winner per IDLE visit is picked round-robin, its op
// is issued to the stack for exactly one cycle (or rejected on full/empty),
// and the result is returned as a one-cycle ack (+err) pulse.
// Sequence: IDLE (sample req) -> ISSUE (stack edge) -> RESP (ack).
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   req/op   [NUM_REQ]    per-requester request and op (1 = push, 0 = pop)
//   wdata [NUM_REQ*DATA_W] push data, slice i at [i*DATA_W +: DATA_W]
//   ack/err  [NUM_REQ]    completion pulse; err marks a rejected op
//   rdata    [DATA_W]     value returned by the last successful pop
//   stk_enable/stk_push_pop/stk_data_in   stack control (this block only)
//   stk_data_out/stk_empty/stk_full       stack status
//   err_count [8]         saturating count of rejected ops
//                         (only when STACK_ARB_ERR_CNT_EN is defined)
//
// Build option: STACK_ARB_ERR_CNT_EN adds the err_count output.
// -----------------------------------------------------------------------------
module stack_arbiter
   import stack_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = DEFAULT_DATA_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        op,
   input  logic [NUM_REQ*DATA_W-1:0] wdata,
   output logic [NUM_REQ-1:0]        ack,
   output logic [NUM_REQ-1:0]        err,
   output logic [DATA_W-1:0]         rdata,
   output logic                      stk_enable,
   output logic                      stk_push_pop,
   output logic [DATA_W-1:0]         stk_data_in,
   input  logic [DATA_W-1:0]         stk_data_out,
   input  logic                      stk_empty,
   input  logic                      stk_full
`ifdef STACK_ARB_ERR_CNT_EN
   ,
   output logic [7:0]                err_count
`endif
);

   localparam int IW = $clog2(NUM_REQ);

   state_t              r_state;
   state_t              w_next_state;
   // Last winner: doubles as the grant index of the op in flight, since the
   // winner of an IDLE visit is by definition the new round-robin anchor.
   logic [IW-1:0]       r_rr_last;
   logic                r_op;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_reject;
   logic                w_reject;
   logic [NUM_REQ-1:0]  w_win_gnt;
   logic [IW-1:0]       w_win_idx;

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_rr (
      .i_req  (req),
      .i_last (r_rr_last),
      .o_gnt  (w_win_gnt),
      .o_idx  (w_win_idx)
   );

   // Flags cannot move between IDLE and ISSUE: this block is the only master.
   assign w_reject = ((r_op == OP_PUSH) && stk_full) ||
                     ((r_op == OP_POP)  && stk_empty);

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   // Outputs are decoded from registered state and latched op/flags only; req
   // never reaches ack, err or stk_enable combinationally.
   always_comb begin
      w_next_state = r_state;
      ack          = '0;
      err          = '0;
      stk_enable   = 1'b0;
      stk_push_pop = 1'b0;
      stk_data_in  = '0;
      case (r_state)
         IDLE: begin
            if (|req) w_next_state = ISSUE;
         end
         ISSUE: begin
            if (!w_reject) begin
               stk_enable   = 1'b1;
               stk_push_pop = r_op;
               stk_data_in  = r_wdata;
            end
            w_next_state = RESP;
         end
         RESP: begin
            ack[r_rr_last] = 1'b1;
            err[r_rr_last] = r_reject;
            w_next_state   = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // NOTE: the latched request fields are reset along with the state so a
   // reset mid-operation leaves nothing stale, and rdata reads 0 afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rr_last <= IW'(NUM_REQ - 1);
         r_op      <= OP_POP;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_reject  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|req) begin
                  r_rr_last <= w_win_idx;
                  r_op      <= |(op & w_win_gnt);
                  r_wdata   <= wdata[int'(w_win_idx)*DATA_W +: DATA_W];
               end
            end
            ISSUE: begin
               r_reject <= w_reject;
               // Top of stack before the pop is what the requester gets back.
               if (!w_reject && (r_op == OP_POP)) r_rdata <= stk_data_out;
            end
            default: ;
         endcase
      end
   end

   assign rdata = r_rdata;

`ifdef STACK_ARB_ERR_CNT_EN
   logic [7:0] r_err_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_err_count <= '0;
      end else if ((r_state == RESP) && r_reject && (r_err_count != 8'hFF)) begin
         r_err_count <= r_err_count + 8'd1;
      end
   end

   assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_stack_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stack_arbiter
// Self-checking bench for stack_arbiter (NUM_REQ=2, DATA_W=8) with a
// behavioural 8-deep LIFO on the stack ports. Expected acks are queued as
// stimulus is driven and compared when the DUT pulses ack.
// -----------------------------------------------------------------------------
module tb_stack_arbiter;
   import stack_arb_pkg::*;

   localparam int NR = 2;
   localparam int DW = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [NR-1:0]     req;
   logic [NR-1:0]     op;
   logic [NR*DW-1:0]  wdata;
   logic [NR-1:0]     ack;
   logic [NR-1:0]     err;
   logic [DW-1:0]     rdata;
   logic              stk_enable;
   logic              stk_push_pop;
   logic [DW-1:0]     stk_data_in;
   logic [DW-1:0]     stk_data_out;
   logic              stk_empty;
   logic              stk_full;
`ifdef STACK_ARB_ERR_CNT_EN
   logic [7:0]        err_count;
`endif

   always #5 clk = ~clk;

   stack_arbiter #(
      .NUM_REQ (NR),
      .DATA_W  (DW)
   ) dut (
`ifdef STACK_ARB_ERR_CNT_EN
      .err_count    (err_count),
`endif
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .op           (op),
      .wdata        (wdata),
      .ack          (ack),
      .err          (err),
      .rdata        (rdata),
      .stk_enable   (stk_enable),
      .stk_push_pop (stk_push_pop),
      .stk_data_in  (stk_data_in),
      .stk_data_out (stk_data_out),
      .stk_empty    (stk_empty),
      .stk_full     (stk_full)
   );

   // Behavioural stack sharing the arbiter's reset.
   logic [DW-1:0] mem [STACK_DEPTH];
   int            cnt;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= 0;
      end else if (stk_enable) begin
         if (stk_push_pop && cnt < STACK_DEPTH) begin
            mem[cnt] <= stk_data_in;
            cnt      <= cnt + 1;
         end else if (!stk_push_pop && cnt > 0) begin
            cnt <= cnt - 1;
         end
      end
   end

   assign stk_empty    = (cnt == 0);
   assign stk_full     = (cnt == STACK_DEPTH);
   assign stk_data_out = (cnt == 0) ? '0 : mem[cnt-1];

   // Bookkeeping
   int n_checks  = 0;
   int n_errors  = 0;
   int en_pulses = 0;

   typedef struct {
      int         idx;
      logic       err;
      logic [7:0] rdata;
   } exp_t;
   exp_t exp_q[$];
   exp_t m_e;
   logic [NR-1:0] m_oh;

   typedef struct {
      bit         rst;
      int         idx;
      logic       op;
      logic [7:0] d;
      logic       e_err;
      logic [7:0] e_rd;
      int         e_en;
      int         flag_chk; // 0 none, 1 expect empty, 2 expect full
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: compare every ack pulse against the oldest expectation.
   always @(negedge clk) begin
      if (!reset) begin
         if (stk_enable) en_pulses++;
         if (ack != '0) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_ack actual=%b required=none", ack);
            end else begin
               m_e  = exp_q.pop_front();
               m_oh = NR'(1) << m_e.idx;
               check("ack_vec", 32'(ack), 32'(m_oh));
               check("err_vec", 32'(err), m_e.err ? 32'(m_oh) : 32'd0);
               check("rdata",   32'(rdata), 32'(m_e.rdata));
            end
         end
      end
   end

   task automatic do_reset();
      check("pending_acks_before_reset", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      reset = 1'b1;
      req   = '0;
      op    = '0;
      wdata = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Single requester op; DUT must be in IDLE on entry.
   task automatic issue(input int idx, input logic o, input logic [7:0] d,
                        input logic e_err, input logic [7:0] e_rd, input int e_en);
      int n   = 0;
      int en0 = en_pulses;
      bit seen = 1'b0;
      exp_q.push_back(exp_t'{idx, e_err, e_rd});
      req[idx]            = 1'b1;
      op[idx]             = o;
      wdata[idx*DW +: DW] = d;
      while (!seen && n < 20) begin
         @(posedge clk);
         #1;
         n++;
         seen = ack[idx];
      end
      check("ack_seen", 32'(seen), 32'd1);
      check("ack_latency", 32'(n), 32'd2);
      check("stk_enable_pulses", 32'(en_pulses - en0), 32'(e_en));
      @(posedge clk);
      #1 req[idx] = 1'b0;
   endtask

   // All requesters request continuously with the given ops until n_acks.
   task automatic contend(input logic [NR-1:0] ops, input int n_acks);
      int got = 0;
      int cyc = 0;
      op  = ops;
      req = '1;
      while (got < n_acks && cyc < 20 * n_acks) begin
         @(posedge clk);
         #1;
         cyc++;
         if (ack != '0) got++;
      end
      check("contention_ack_count", 32'(got), 32'(n_acks));
      req = '0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Test 1: LIFO order, single requester 0.
      vecs.push_back(vec_t'{1, 0, OP_PUSH, 8'h11, 0, 8'h00, 1, 0});
      vecs.push_back(vec_t'{0, 0, OP_PUSH, 8'h22, 0, 8'h00, 1, 0});
      vecs.push_back(vec_t'{0, 0, OP_PUSH, 8'h33, 0, 8'h00, 1, 0});
      vecs.push_back(vec_t'{0, 0, OP_POP,  8'h00, 0, 8'h33, 1, 0});
      vecs.push_back(vec_t'{0, 0, OP_POP,  8'h00, 0, 8'h22, 1, 0});
      vecs.push_back(vec_t'{0, 0, OP_POP,  8'h00, 0, 8'h11, 1, 1});
      // Test 3: fill to full, rejected 9th push, pop returns last accepted.
      for (int i = 1; i <= 8; i++)
         vecs.push_back(vec_t'{(i == 1), 0, OP_PUSH, 8'(i), 0, 8'h00, 1, (i == 8) ? 2 : 0});
      vecs.push_back(vec_t'{0, 0, OP_PUSH, 8'hFF, 1, 8'h00, 0, 2});
      vecs.push_back(vec_t'{0, 0, OP_POP,  8'h00, 0, 8'h08, 1, 0});
      // Test 4: pop on empty right after reset.
      vecs.push_back(vec_t'{1, 0, OP_POP,  8'h00, 1, 8'h00, 0, 1});

      do_reset();
      check("rst_ack",          32'(ack), 32'd0);
      check("rst_err",          32'(err), 32'd0);
      check("rst_rdata",        32'(rdata), 32'd0);
      check("rst_stk_enable",   32'(stk_enable), 32'd0);
      check("rst_stk_push_pop", 32'(stk_push_pop), 32'd0);
      check("rst_stk_data_in",  32'(stk_data_in), 32'd0);

      foreach (vecs[i]) begin
         if (vecs[i].rst) do_reset();
         issue(vecs[i].idx, vecs[i].op, vecs[i].d, vecs[i].e_err, vecs[i].e_rd, vecs[i].e_en);
         if (vecs[i].flag_chk == 1) check("stk_empty", 32'(stk_empty), 32'd1);
         if (vecs[i].flag_chk == 2) check("stk_full",  32'(stk_full),  32'd1);
      end
`ifdef STACK_ARB_ERR_CNT_EN
      check("err_count_one", 32'(err_count), 32'd1);
`endif

      // Test 2: preload via requester 1, then both pop continuously.
      do_reset();
      for (int i = 0; i < 4; i++) issue(1, OP_PUSH, 8'hA0 + 8'(i), 0, 8'h00, 1);
      exp_q.push_back(exp_t'{0, 0, 8'hA3});
      exp_q.push_back(exp_t'{1, 0, 8'hA2});
      exp_q.push_back(exp_t'{0, 0, 8'hA1});
      exp_q.push_back(exp_t'{1, 0, 8'hA0});
      contend({OP_POP, OP_POP}, 4);
      check("contention_empty", 32'(stk_empty), 32'd1);
      check("contention_rdata_hold", 32'(rdata), 32'hA0);

      // Test 5: reset during ISSUE of a push of 0x5A.
      req[0]       = 1'b1;
      op[0]        = OP_PUSH;
      wdata[7:0]   = 8'h5A;
      @(posedge clk);
      #1;
      check("issue_stk_enable",   32'(stk_enable), 32'd1);
      check("issue_stk_push_pop", 32'(stk_push_pop), 32'd1);
      check("issue_stk_data_in",  32'(stk_data_in), 32'h5A);
      #1 reset = 1'b1;
      req = '0;
      #1;
      check("midrst_ack",          32'(ack), 32'd0);
      check("midrst_err",          32'(err), 32'd0);
      check("midrst_rdata",        32'(rdata), 32'd0);
      check("midrst_stk_enable",   32'(stk_enable), 32'd0);
      check("midrst_stk_push_pop", 32'(stk_push_pop), 32'd0);
      check("midrst_stk_data_in",  32'(stk_data_in), 32'd0);
      check("midrst_state",        32'(dut.r_state), 32'(IDLE));
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("midrst_push_dropped", 32'(stk_empty), 32'd1);
      exp_q.push_back(exp_t'{0, 1, 8'h00});
      exp_q.push_back(exp_t'{1, 1, 8'h00});
      contend({OP_POP, OP_POP}, 2);

`ifdef STACK_ARB_ERR_CNT_EN
      // Saturation of the reject counter.
      do_reset();
      for (int i = 0; i < 300; i++) issue(0, OP_POP, 8'h00, 1, 8'h00, 0);
      check("err_count_saturated", 32'(err_count), 32'd255);
`endif

      check("pending_acks_end", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
Shares one 8-deep x 8-bit LIFO stack (push/pop, full/empty flags, combinational top-of-stack output) between NUM_REQ requesters. The block accepts push/pop requests over a req/ack handshake and picks one winner by round-robin. It checks the stack's full/empty flags, drives the stack's enable/push_pop/data_in for one cycle, and returns popped data or an error to the winner. It is the only master of the stack's control inputs.

Parameters:
NUM_REQ, 2, number of requesters (legal 2..4)
DATA_W, 8, data width; must equal the stack width

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
req  input  NUM_REQ  per-requester request; held high until its ack
op  input  NUM_REQ  per-requester operation: 1 = push, 0 = pop
wdata  input  NUM_REQ*DATA_W  per-requester push data; slice i = bits [i*DATA_W +: DATA_W]
ack  output  NUM_REQ  one-cycle completion pulse to the served requester
err  output  NUM_REQ  asserted with ack when the op was rejected (push on full, pop on empty)
rdata  output  DATA_W  popped value; valid in the ack cycle of a successful pop
stk_enable  output  1  to stack enable
stk_push_pop  output  1  to stack push_pop
stk_data_in  output  DATA_W  to stack data_in
stk_data_out  input  DATA_W  stack top-of-stack (0 when empty)
stk_empty  input  1  stack empty flag
stk_full  input  1  stack full flag

Behaviour:
- Reset values: ack=0, err=0, rdata=0, stk_enable=0, stk_push_pop=0, stk_data_in=0, state=IDLE, rr_last=NUM_REQ-1 (requester 0 has first priority).
- FSM has three states: IDLE -> ISSUE -> RESP -> IDLE.
- IDLE:
  - If no req bit is set, stay in IDLE.
  - Otherwise pick the winner round-robin, searching from rr_last+1 upward with wrap-around.
  - Latch the winner index into gnt_idx, and latch op[gnt_idx] and wdata slice.
  - Set rr_last=gnt_idx and go to ISSUE.
- ISSUE:
  - reject = (op==push && stk_full) || (op==pop && stk_empty).
  - If not reject: stk_enable=1 for exactly this cycle, stk_push_pop=latched op, stk_data_in=latched wdata.
  - On a successful pop, capture rdata<=stk_data_out at this edge. That value is the top of stack before the pop.
  - If reject: stk_enable stays 0 and the stack is untouched.
  - Go to RESP.
- RESP:
  - ack[gnt_idx]=1 and err[gnt_idx]=reject. All other ack/err bits are 0.
  - rdata holds its value. It is unchanged after a push or a rejected op.
  - Go to IDLE.
- stk_enable, ack and err are decoded from registered state and latched flags, with no combinational path from req.
- Latency: request sampled in IDLE at cycle N, stack edge at the end of cycle N+1, ack in cycle N+2. Peak throughput is one op per 3 cycles.
- Handshake:
  - The requester keeps req, op and wdata stable until it sees ack.
  - It drops req in the cycle after ack, or keeps req high to issue a new op.
  - A requester that keeps req high competes again in the next IDLE under round-robin.
- Flags are stable from IDLE through ISSUE because no other master drives the stack.
- Boundaries:
  - Push when the stack holds 7 entries: accepted; stack_full rises afterwards.
  - Push when full: err=1, data discarded.
  - Pop of the last entry: returns the value; stack_empty rises afterwards.
  - Pop when empty: err=1, rdata unchanged.
- Simultaneous requests: exactly one winner per IDLE visit. Under continuous contention the requesters alternate, so none starves.
- Reset asserted mid-operation forces IDLE immediately and clears all outputs. An in-flight op is dropped with no ack; the stack is expected to share the same reset.

Optional Feature:
STACK_ARB_ERR_CNT_EN:
- Defined: adds output err_count [7:0], reset to 0. It increments by 1 in each RESP cycle with reject=1 and saturates at 255.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package stack_arb_pkg holds:
  - state encoding IDLE/ISSUE/RESP (2-bit typedef);
  - constants OP_PUSH=1'b1, OP_POP=1'b0;
  - default DATA_W=8 and STACK_DEPTH=8.
- One sub-module, rr_arbiter (parameter N): inputs req and last index, outputs a one-hot grant and the binary index. It is purely combinational; stack_arbiter holds rr_last.

Test Plan:
- Single requester 0 pushes 0x11, 0x22, 0x33, then pops 3 times -> three acks with err=0; rdata 0x33, 0x22, 0x11; stk_empty=1 at the end.
- Req0 and req1 both pop-request continuously on a stack preloaded with 0xA0..0xA3 -> acks alternate 0,1,0,1; rdata 0xA3, 0xA2, 0xA1, 0xA0.
- Push 8 values 0x01..0x08, then a 9th push of 0xFF -> 9th ack has err=1; stk_enable stays 0 in that ISSUE; a following pop returns 0x08.
- Pop on an empty stack after reset -> ack with err=1, rdata=0x00, stk_enable never pulses; with STACK_ARB_ERR_CNT_EN, err_count=1.
- Assert reset during the ISSUE of a push of 0x5A -> no ack, all outputs 0, FSM in IDLE; after release, requester 0 wins first.
- With STACK_ARB_ERR_CNT_EN, issue 300 empty pops -> err_count saturates at 255.
